pipe_sort_n: RTL and testbench

Parametrised, fully pipelined sorting network with valid/ready flow control. Each accepted beat carries N unsigned DW-bit elements and leaves N cycles later fully sorted, ascending or descending as selected per beat. It replaces fixed four-element insertion sorters in the datapath wherever sort width, direction or backpressure must vary.

---
 rtl/pipe_sort_n.sv | 121 ++++++++++++
 tb/tb_pipe_sort_n.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_sort_n.sv
// Pipelined odd-even transposition sorter: N compare-exchange layers, each followed by a register stage.
// Latency: N register stages. Backpressure: bubble-collapsing stall chain, holds up to N beats. Index tags with PIPE_SORT_INDEX_EN.
module pipe_sort_n #(
    parameter int DW = 8,
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N*DW-1:0] in_data,
    input  logic            in_desc,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [N*DW-1:0] out_data,
    output logic [N*IW-1:0] out_idx,
    output logic            out_valid,
    input  logic            out_ready
);

    // Index k of every per-stage array is register stage k+1; src_* is what feeds layer k.
    logic [N-1:0][N-1:0][DW-1:0] dat_q;
    logic [N-1:0][N-1:0][DW-1:0] src_dat;
    logic [N-1:0][N-1:0][DW-1:0] lay_dat;
    logic [N-1:0]                v_q;
    logic [N-1:0]                desc_q;
    logic [N-1:0]                src_vld;
    logic [N-1:0]                src_desc;
    logic [N-1:0]                en;

    assign src_dat  = {dat_q[N-2:0], in_data};
    assign src_vld  = {v_q[N-2:0], in_valid};
    assign src_desc = {desc_q[N-2:0], in_desc};

`ifdef PIPE_SORT_INDEX_EN
    logic [N-1:0][N-1:0][IW-1:0] idx_q;
    logic [N-1:0][N-1:0][IW-1:0] src_idx;
    logic [N-1:0][N-1:0][IW-1:0] lay_idx;
    logic [N-1:0][IW-1:0]        in_idx;

    always_comb begin
        in_idx = '0;
        for (int i = 0; i < N; i++) begin
            in_idx[i] = IW'(i);
        end
    end

    assign src_idx = {idx_q[N-2:0], in_idx};
`endif

    // Layer s pairs (i, i+1) with i of the same parity as s; edge elements fall through.
    always_comb begin
        logic [DW-1:0] lo;
        logic [DW-1:0] hi;
        logic          swap;
        lo      = '0;
        hi      = '0;
        swap    = 1'b0;
        lay_dat = src_dat;
`ifdef PIPE_SORT_INDEX_EN
        lay_idx = src_idx;
`endif
        for (int s = 0; s < N; s++) begin
            for (int i = 0; i < N - 1; i++) begin
                if ((i % 2) == (s % 2)) begin
                    lo   = lay_dat[s][i];
                    hi   = lay_dat[s][i+1];
                    swap = src_desc[s] ? (lo < hi) : (lo > hi);
                    if (swap) begin
                        lay_dat[s][i]   = hi;
                        lay_dat[s][i+1] = lo;
`ifdef PIPE_SORT_INDEX_EN
                        lay_idx[s][i]   = src_idx[s][i+1];
                        lay_idx[s][i+1] = src_idx[s][i];
`endif
                    end
                end
            end
        end
    end

    // A stage may load when it is empty or when the stage below it is moving.
    always_comb begin
        en        = '0;
        en[N-1]   = !v_q[N-1] || out_ready;
        for (int k = N - 2; k >= 0; k--) begin
            en[k] = !v_q[k] || en[k+1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_q    <= '0;
            desc_q <= '0;
            dat_q  <= '0;
`ifdef PIPE_SORT_INDEX_EN
            idx_q  <= '0;
`endif
        end else begin
            for (int k = 0; k < N; k++) begin
                if (en[k]) begin
                    v_q[k]    <= src_vld[k];
                    desc_q[k] <= src_desc[k];
                    dat_q[k]  <= lay_dat[k];
`ifdef PIPE_SORT_INDEX_EN
                    idx_q[k]  <= lay_idx[k];
`endif
                end
            end
        end
    end

    assign in_ready  = en[0];
    assign out_valid = v_q[N-1];
    assign out_data  = dat_q[N-1];
`ifdef PIPE_SORT_INDEX_EN
    assign out_idx   = idx_q[N-1];
`else
    assign out_idx   = '0;
`endif

endmodule

// File: tb/tb_pipe_sort_n.sv
// Bench for pipe_sort_n: directed sorts, randomized streams with backpressure against a key-sorting model, reset mid-flight.
module tb_pipe_sort_n;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] in_data;
    logic        in_desc, in_valid, in_ready;
    logic [31:0] out_data;
    logic [7:0]  out_idx;
    logic        out_valid, out_ready;

    logic [79:0] d5_in_data;
    logic        d5_in_desc, d5_in_valid, d5_in_ready;
    logic [79:0] d5_out_data;
    logic [14:0] d5_out_idx;
    logic        d5_out_valid, d5_out_ready;

    always #5 clk = ~clk;

    pipe_sort_n #(.DW(8), .N(4)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_desc(in_desc), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_idx(out_idx), .out_valid(out_valid), .out_ready(out_ready)
    );

    pipe_sort_n #(.DW(16), .N(5)) u_dut5 (
        .clk(clk), .rst_n(rst_n),
        .in_data(d5_in_data), .in_desc(d5_in_desc), .in_valid(d5_in_valid), .in_ready(d5_in_ready),
        .out_data(d5_out_data), .out_idx(d5_out_idx), .out_valid(d5_out_valid), .out_ready(d5_out_ready)
    );

    typedef struct {
        logic [31:0] d;
        logic [7:0]  i;
    } exp_t;

    exp_t        q[$];
    int          n_chk = 0;
    int          n_pass = 0;
    int          n_emit = 0;
    bit          stalled_prev = 0;
    logic [31:0] prev_dat;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: sort (key, position) pairs; the key folds direction in, position breaks ties.
    function automatic void ref_sort(input int n, input int dw, input int iw, input logic [79:0] d,
                                     input bit desc, output logic [79:0] od, output logic [79:0] oi);
        longint keys[$];
        longint mask, v;
        int     p;
        mask = (longint'(1) << dw) - 1;
        od = '0;
        oi = '0;
        for (int i = 0; i < n; i++) begin
            v = longint'(d >> (dw * i)) & mask;
            keys.push_back((desc ? mask - v : v) * n + i);
        end
        keys.sort();
        for (int j = 0; j < n; j++) begin
            p  = int'(keys[j] % n);
            v  = longint'(d >> (dw * p)) & mask;
            od = od | (80'(v) << (dw * j));
            oi = oi | (80'(p) << (iw * j));
        end
    endfunction

    function automatic logic [7:0] midx4(input logic [31:0] d, input bit ds);
        logic [79:0] od, oi;
        ref_sort(4, 8, 2, {48'h0, d}, ds, od, oi);
        return oi[7:0];
    endfunction

    function automatic logic [7:0] exp_idx(input logic [7:0] ei);
`ifdef PIPE_SORT_INDEX_EN
        return ei;
`else
        return 8'h0;
`endif
    endfunction

    // One clock of the 4-wide DUT with scoreboard checking, sampled at the falling edge.
    task automatic cycle(output bit acc);
        exp_t        e;
        logic [79:0] od, oi;
        @(negedge clk);
        chk("in_ready_occ", in_ready, (q.size() < 4) || out_ready);
        if (stalled_prev) begin
            chk("stall_hold_dat", out_data, prev_dat);
            chk("stall_hold_vld", out_valid, 1);
        end
        if (out_valid && out_ready) begin
            n_emit++;
            if (q.size() == 0) begin
                chk("sb_underflow", out_valid, 0);
            end else begin
                e = q.pop_front();
                chk("sb_dat", out_data, e.d);
                chk("sb_idx", out_idx, exp_idx(e.i));
            end
        end
        stalled_prev = out_valid && !out_ready;
        prev_dat     = out_data;
        acc          = in_valid && in_ready;
        if (acc) begin
            ref_sort(4, 8, 2, {48'h0, in_data}, in_desc, od, oi);
            e.d = od[31:0];
            e.i = oi[7:0];
            q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send4(input string tag, input logic [31:0] d, input bit ds,
                         input logic [31:0] ed, input logic [7:0] ei);
        int lat;
        out_ready = 1'b1;
        in_data   = d;
        in_desc   = ds;
        in_valid  = 1'b1;
        @(negedge clk);
        chk({tag, "_rdy"}, in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_lat"}, lat, 4);
        chk({tag, "_vld"}, out_valid, 1);
        chk({tag, "_dat"}, out_data, ed);
        chk({tag, "_idx"}, out_idx, exp_idx(ei));
        @(posedge clk);
        #1;
        stalled_prev = 0;
    endtask

    task automatic send5(input string tag, input logic [79:0] d, input bit ds, input logic [79:0] ed);
        int lat;
        d5_out_ready = 1'b1;
        d5_in_data   = d;
        d5_in_desc   = ds;
        d5_in_valid  = 1'b1;
        @(posedge clk);
        #1;
        d5_in_valid = 1'b0;
        lat = 1;
        while (!d5_out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_lat"}, lat, 5);
        chk({tag, "_dat"}, d5_out_data, ed);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
        $fatal(1, "time limit");
    end

    initial begin
        bit          acc, saw_drop;
        int          sent;
        logic [79:0] od, oi;
        logic [79:0] r5;

        rst_n = 1'b0;
        in_data = '0; in_desc = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        d5_in_data = '0; d5_in_desc = 1'b0; d5_in_valid = 1'b0; d5_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_idx", out_idx, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst5_out_valid", d5_out_valid, 0);

        // Directed ascending, descending and tie-stability beats.
        send4("asc", 32'h03C80701, 1'b0, 32'hC8070301, midx4(32'h03C80701, 1'b0));
        send4("desc", 32'h03C80701, 1'b1, 32'h010307C8, midx4(32'h03C80701, 1'b1));
        send4("ties", 32'h05020505, 1'b0, 32'h05050502, 8'hD2);

        // Back-to-back beats alternating direction.
        stalled_prev = 0;
        for (int j = 0; j < 20; j++) begin
            in_valid = 1'b1;
            in_data  = $urandom;
            in_desc  = j[0];
            out_ready = 1'b1;
            cycle(acc);
        end
        in_valid = 1'b0;
        for (int c = 0; c < 20 && q.size() > 0; c++) cycle(acc);
        chk("alt_drain", q.size(), 0);

        // Six beats streamed with a three-cycle output stall.
        sent = 0;
        saw_drop = 0;
        n_emit = 0;
        for (int c = 0; c < 40 && (sent < 6 || q.size() > 0); c++) begin
            in_valid  = (sent < 6);
            in_data   = $urandom;
            in_desc   = $urandom_range(0, 1);
            out_ready = !(c >= 3 && c < 6);
            if (!in_ready) saw_drop = 1;
            cycle(acc);
            if (acc) sent++;
        end
        out_ready = 1'b1;
        chk("bp_sent", sent, 6);
        chk("bp_emit", n_emit, 6);
        chk("bp_drain", q.size(), 0);
        chk("bp_ready_drop", saw_drop, 1);

        // Random valid and ready.
        for (int c = 0; c < 80; c++) begin
            in_valid  = $urandom_range(0, 1);
            in_data   = $urandom;
            in_desc   = $urandom_range(0, 1);
            out_ready = ($urandom_range(0, 3) != 0);
            cycle(acc);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 20 && q.size() > 0; c++) cycle(acc);
        chk("rand_drain", q.size(), 0);

        // Reset with three beats in flight: none may ever emerge.
        for (int j = 0; j < 3; j++) begin
            in_valid = 1'b1;
            in_data  = $urandom;
            in_desc  = $urandom_range(0, 1);
            cycle(acc);
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        q.delete();
        stalled_prev = 0;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_data", out_data, 0);
        chk("midrst_in_ready", in_ready, 1);
        n_emit = 0;
        for (int c = 0; c < 8; c++) cycle(acc);
        chk("midrst_no_ghost", n_emit, 0);
        send4("post_rst", 32'h7F00FF10, 1'b0, 32'hFF7F1000, midx4(32'h7F00FF10, 1'b0));

        // Five-wide, 16-bit extremes.
        send5("ext5", 80'hFFFF_0001_8000_0000_FFFF, 1'b0, 80'hFFFF_FFFF_8000_0001_0000);
        r5 = {$urandom, $urandom, $urandom} & 80'hFFFF_FFFF_FFFF_FFFF_FFFF;
        ref_sort(5, 16, 3, r5, 1'b1, od, oi);
        send5("rand5_desc", r5, 1'b1, od);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
